// File: rtl/ysyx_25030085_lsu.sv
//==============================================================================
// Module      : ysyx_25030085_lsu
// Description : Blocking load/store unit. Accepts one access at a time from the
//               EXU, runs a req/gnt + rvalid bus transaction, and returns
//               lane-extracted, sign/zero-extended load data with an error flag.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ysyx_25030085_lsu #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Last counter value on which REQ/WAIT may still make progress.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [1:0]       off_q;
  logic [2:0]       funct3_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_bad;
  logic        w_timeout;
  logic [31:0] w_fmt_wdata;
  logic [3:0]  w_fmt_wstrb;
  logic [31:0] w_load_data;
  logic [31:0] w_shifted;

  assign w_accept  = (state_q == S_IDLE) && lsu_valid_i && (is_load_i || is_store_i);
  assign w_timeout = (cnt_q >= TO_LAST);

  // Classify the incoming request: illegal width code, misalignment, or conflicting type flags.
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (is_load_i) begin
      w_illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    end else begin
      w_illegal = (funct3_i > 3'b010);
    end
    case (funct3_i[1:0])
      2'b01:   w_misaligned = addr_i[0];
      2'b10:   w_misaligned = (addr_i[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
    w_bad = w_illegal || w_misaligned || (is_load_i && is_store_i);
  end

  // Replicate store data into every lane and select the byte enables for the access size.
  always_comb begin
    w_fmt_wdata = wdata_i;
    w_fmt_wstrb = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        w_fmt_wdata = {4{wdata_i[7:0]}};
        w_fmt_wstrb = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        w_fmt_wdata = {2{wdata_i[15:0]}};
        w_fmt_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_fmt_wdata = wdata_i;
        w_fmt_wstrb = 4'b1111;
      end
    endcase
  end

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  always_comb begin
    w_shifted   = mem_rdata_i >> {off_q, 3'b000};
    w_load_data = mem_rdata_i;
    case (funct3_q)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = mem_rdata_i;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; errors detected at accept skip the bus entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_accept) state_d = w_bad ? S_RESP : S_REQ;
      S_REQ: begin
        if (mem_gnt_i)      state_d = S_WAIT;
        else if (w_timeout) state_d = S_RESP;
      end
      S_WAIT: begin
        if (mem_rvalid_i)   state_d = S_RESP;
        else if (w_timeout) state_d = S_RESP;
      end
      default:              state_d = S_IDLE;
    endcase
  end

  // Request latch, timeout counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            cnt_q    <= '0;
            addr_q   <= {addr_i[31:2], 2'b00};
            off_q    <= addr_i[1:0];
            funct3_q <= funct3_i;
            we_q     <= is_store_i && !w_bad;
            wdata_q  <= w_fmt_wdata;
            wstrb_q  <= (is_store_i && !w_bad) ? w_fmt_wstrb : 4'b0000;
            rdata_q  <= '0;
            err_q    <= w_bad;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (!mem_gnt_i && w_timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_rvalid_i) begin
            rdata_q <= we_q ? 32'd0 : w_load_data;
          end else if (w_timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign lsu_ready_o = (state_q == S_IDLE);
  assign mem_req_o   = (state_q == S_REQ);
  assign done_o      = (state_q == S_RESP);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25030085_lsu.sv
//==============================================================================
// Module      : tb_ysyx_25030085_lsu
// Description : Directed plus randomized bench for the load/store unit against a
//               byte-lane reference model of RV32I loads and stores.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ysyx_25030085_lsu;

  localparam int TIMEOUT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  int nvec = 0;
  int nerr = 0;

  ysyx_25030085_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
    .is_load_i(is_load), .is_store_i(is_store), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .done_o(done), .rdata_o(rdata), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // An access is rejected if flags conflict, width code is not legal, or address is not a size multiple.
  function automatic logic model_err(input logic ld, input logic st, input logic [2:0] f3,
                                     input logic [31:0] a);
    bit legal;
    if (ld && st) return 1'b1;
    if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else    legal = (f3 <= 3'd2);
    if (!legal) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    longint unsigned v;
    longint unsigned mask;
    int bits;
    bits = 8 * acc_size(f3);
    v    = longint'(word) >> (8 * (a % 4));
    if (bits == 32) return word;
    mask = (64'd1 << bits) - 1;
    v    = v & mask;
    if (!f3[2] && v[bits-1]) v = v | (64'hFFFF_FFFF & ~mask);
    return v[31:0];
  endfunction

  task automatic run(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rw, input int gd, input int rd);
    logic        e;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    int          need, exp_lat, cyc, rq, wt, sz, off;
    logic        granted;
    e      = model_err(ld, st, f3, a);
    sz     = acc_size(f3);
    off    = a % 4;
    exp_wd = 32'd0;
    exp_st = 4'd0;
    for (int k = 0; k < 4; k++) begin
      exp_wd[8*k +: 8] = wd[8*(k % sz) +: 8];
      exp_st[k]        = (k >= off) && (k < off + sz);
    end
    need = gd + rd + 2;
    if (e) begin
      exp_lat = 1; exp_rd = 32'd0;
    end else if (need > TIMEOUT) begin
      exp_lat = TIMEOUT + 1; exp_rd = 32'd0; e = 1'b1;
    end else begin
      exp_lat = need + 1; exp_rd = ld ? model_load(f3, a, rw) : 32'd0;
    end

    lsu_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    chk("ready_idle", {31'd0, lsu_ready}, 32'd1);
    @(posedge clk); #1;
    lsu_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; wdata = $urandom; addr = $urandom;
    cyc = 1; rq = 0; wt = 0; granted = 1'b0;
    chk("ready_busy", {31'd0, lsu_ready}, 32'd0);
    while (!done && cyc < 20) begin
      if (!granted) begin
        chk("req_hi", {31'd0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_we", {31'd0, mem_we}, {31'd0, st});
        chk("mem_wstrb", {28'd0, mem_wstrb}, st ? {28'd0, exp_st} : 32'd0);
        if (st) chk("mem_wdata", mem_wdata, exp_wd);
        if (rq == gd) begin mem_gnt = 1'b1; granted = 1'b1; end
        rq++;
      end else begin
        chk("req_lo_wait", {31'd0, mem_req}, 32'd0);
        if (wt == rd) begin mem_rvalid = 1'b1; mem_rdata = rw; end
        else mem_rdata = $urandom;
        wt++;
      end
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      cyc++;
    end
    chk("latency", cyc, exp_lat);
    chk("done", {31'd0, done}, 32'd1);
    chk("err", {31'd0, err}, {31'd0, e});
    chk("rdata", rdata, exp_rd);
    chk("req_lo_resp", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("ready_back", {31'd0, lsu_ready}, 32'd1);
    chk("rdata_hold", rdata, exp_rd);
    chk("err_hold", {31'd0, err}, {31'd0, e});
  endtask

  initial begin
    logic        r_ld, r_st;
    logic [2:0]  r_f3;
    int          sel;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);

    // Directed cases
    run(1, 0, 3'b010, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 0, 0);
    chk("lw_literal", rdata, 32'hDEAD_BEEF);
    run(1, 0, 3'b000, 32'h8000_0003, 32'd0, 32'h8012_3456, 0, 0);
    chk("lb_literal", rdata, 32'hFFFF_FF80);
    run(1, 0, 3'b100, 32'h8000_0003, 32'd0, 32'h8012_3456, 0, 0);
    chk("lbu_literal", rdata, 32'h0000_0080);
    run(1, 0, 3'b101, 32'h8000_0002, 32'd0, 32'h8001_5678, 0, 0);
    chk("lhu_literal", rdata, 32'h0000_8001);
    run(0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'd0, 0, 0);
    run(0, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'd0, 1, 1);
    run(1, 0, 3'b010, 32'h8000_0002, 32'd0, 32'd0, 0, 0);
    run(1, 1, 3'b010, 32'h8000_0000, 32'h5555_AAAA, 32'd0, 0, 0);
    run(1, 0, 3'b010, 32'h0000_1000, 32'd0, 32'hCAFE_F00D, 3, 0);
    run(1, 0, 3'b010, 32'h0000_2000, 32'd0, 32'h0, 0, 100);

    // A request with neither flag set is ignored
    lsu_valid = 1'b1; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    chk("neither_ready", {31'd0, lsu_ready}, 32'd1);
    chk("neither_req", {31'd0, mem_req}, 32'd0);

    // Reset in WAIT, then a late rvalid in IDLE
    lsu_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h100;
    @(posedge clk); #1;
    lsu_valid = 1'b0; is_load = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    chk("rst_wait_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("late_rv_done", {31'd0, done}, 32'd0);
    chk("late_rv_ready", {31'd0, lsu_ready}, 32'd1);
    run(1, 0, 3'b010, 32'h0000_0200, 32'd0, 32'h0BAD_CAFE, 0, 0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      sel  = $urandom_range(0, 14);
      r_ld = (sel < 7) || (sel == 14);
      r_st = (sel >= 7);
      r_f3 = 3'($urandom_range(0, 7));
      run(r_ld, r_st, r_f3, $urandom, $urandom, $urandom,
          $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
